// File: rtl/rvfi_causal_pkg.sv
// Shared types and constants for the RVFI register-causality checker.
package rvfi_causal_pkg;

  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_RAW  = 2'd1,
    ERR_WAW  = 2'd2
  } err_kind_e;

endpackage

// File: rtl/rvfi_causal_reg_tracker.sv
// Per-register max-order tracker: value plus valid bit, N-way same-cycle update.
// Entry 0 is never written, so it stays empty forever.
module rvfi_causal_reg_tracker
  import rvfi_causal_pkg::*;
#(
  parameter int NUPD    = 2,
  parameter int ORDER_W = 64
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUPD-1:0]                   upd_vld,
  input  logic [NUPD-1:0][4:0]              upd_addr,
  input  logic [NUPD-1:0][ORDER_W-1:0]      upd_ord,
  output logic [NREGS-1:0][ORDER_W-1:0]     max_q,
  output logic [NREGS-1:0]                  vld_q
);

  logic [NREGS-1:0][ORDER_W-1:0] max_d;
  logic [NREGS-1:0]              vld_d;

  // Fold every update port into the table; colliding ports reduce to one max.
  always_comb begin
    max_d = max_q;
    vld_d = vld_q;
    for (int p = 0; p < NUPD; p++) begin
      if (upd_vld[p] && upd_addr[p] != 5'd0) begin
        vld_d[upd_addr[p]] = 1'b1;
        if (upd_ord[p] > max_d[upd_addr[p]]) max_d[upd_addr[p]] = upd_ord[p];
      end
    end
  end

  // Table state; reset discards all history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
      vld_q <= '0;
    end else begin
      max_q <= max_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/rvfi_causal_multi_check.sv
// Multi-channel RVFI register-causality checker (RAW, optional WAW) with
// first-violation capture and a saturating checked-writer counter.
module rvfi_causal_multi_check
  import rvfi_causal_pkg::*;
#(
  parameter int NRET      = 1,
  parameter int ORDER_W   = 64,
  parameter int CHECK_WAW = 0,
  parameter int CNT_W     = 16,
  localparam int CH_W     = $clog2(NRET) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET*5-1:0]       rvfi_rs1_addr,
  input  logic [NRET*5-1:0]       rvfi_rs2_addr,
  input  logic [NRET*5-1:0]       rvfi_rd_addr,
  output logic                    err,
  output logic [1:0]              err_kind,
  output logic [CH_W-1:0]         err_channel,
  output logic [4:0]              err_reg,
  output logic [ORDER_W-1:0]      err_order,
  output logic [CNT_W-1:0]        checked_count
);

  localparam int SUM_W = CNT_W + CH_W + 1;

  logic [NRET-1:0][ORDER_W-1:0] ord;
  logic [NRET-1:0][4:0]         rs1, rs2, rd;
  assign ord = rvfi_order;
  assign rs1 = rvfi_rs1_addr;
  assign rs2 = rvfi_rs2_addr;
  assign rd  = rvfi_rd_addr;

  logic [2*NRET-1:0]              ru_vld;
  logic [2*NRET-1:0][4:0]         ru_addr;
  logic [2*NRET-1:0][ORDER_W-1:0] ru_ord;

  // Each channel contributes two read ports (rs1, rs2) to the read tracker.
  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      ru_vld[2*c]    = rvfi_valid[c];
      ru_vld[2*c+1]  = rvfi_valid[c];
      ru_addr[2*c]   = rs1[c];
      ru_addr[2*c+1] = rs2[c];
      ru_ord[2*c]    = ord[c];
      ru_ord[2*c+1]  = ord[c];
    end
  end

  logic [NREGS-1:0][ORDER_W-1:0] rd_max, wr_max;
  logic [NREGS-1:0]              rd_vld, wr_vld;

  rvfi_causal_reg_tracker #(.NUPD(2*NRET), .ORDER_W(ORDER_W)) u_rd_trk (
    .clock(clock), .reset(reset),
    .upd_vld(ru_vld), .upd_addr(ru_addr), .upd_ord(ru_ord),
    .max_q(rd_max), .vld_q(rd_vld)
  );

  if (CHECK_WAW != 0) begin : g_waw
    rvfi_causal_reg_tracker #(.NUPD(NRET), .ORDER_W(ORDER_W)) u_wr_trk (
      .clock(clock), .reset(reset),
      .upd_vld(rvfi_valid), .upd_addr(rd), .upd_ord(ord),
      .max_q(wr_max), .vld_q(wr_vld)
    );
  end else begin : g_no_waw
    assign wr_max = '0;
    assign wr_vld = '0;
  end

  logic [NRET-1:0] wchk, raw, waw;

  // Table check plus same-cycle cross-channel check against lower channels only.
  always_comb begin
    wchk = '0;
    raw  = '0;
    waw  = '0;
    for (int c = 0; c < NRET; c++) begin
      wchk[c] = rvfi_valid[c] && rd[c] != 5'd0 && enable;
      if (wchk[c]) begin
        if (rd_vld[rd[c]] && rd_max[rd[c]] > ord[c]) raw[c] = 1'b1;
        if (CHECK_WAW != 0 && wr_vld[rd[c]] && wr_max[rd[c]] > ord[c]) waw[c] = 1'b1;
        for (int k = 0; k < c; k++) begin
          if (rvfi_valid[k] && ord[k] > ord[c]) begin
            if (rs1[k] == rd[c] || rs2[k] == rd[c]) raw[c] = 1'b1;
            if (CHECK_WAW != 0 && rd[k] == rd[c]) waw[c] = 1'b1;
          end
        end
      end
    end
  end

  logic               hit;
  err_kind_e          hit_kind;
  logic [CH_W-1:0]    hit_ch;
  logic [4:0]         hit_reg;
  logic [ORDER_W-1:0] hit_ord;

  // Lowest violating channel wins; RAW outranks WAW within a channel.
  always_comb begin
    hit      = 1'b0;
    hit_kind = ERR_NONE;
    hit_ch   = '0;
    hit_reg  = '0;
    hit_ord  = '0;
    for (int c = 0; c < NRET; c++) begin
      if (!hit && (raw[c] || waw[c])) begin
        hit      = 1'b1;
        hit_kind = raw[c] ? ERR_RAW : ERR_WAW;
        hit_ch   = CH_W'(c);
        hit_reg  = rd[c];
        hit_ord  = ord[c];
      end
    end
  end

  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_d;

  // Add this cycle's checked writers, clamping at all-ones.
  always_comb begin
    cnt_sum = SUM_W'(checked_count);
    for (int c = 0; c < NRET; c++)
      if (wchk[c]) cnt_sum = cnt_sum + SUM_W'(1);
    if (cnt_sum > SUM_W'({CNT_W{1'b1}})) cnt_d = '1;
    else                                 cnt_d = cnt_sum[CNT_W-1:0];
  end

  // Sticky first-violation capture and counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err           <= 1'b0;
      err_kind      <= ERR_NONE;
      err_channel   <= '0;
      err_reg       <= '0;
      err_order     <= '0;
      checked_count <= '0;
    end else begin
      checked_count <= cnt_d;
      if (!err && hit) begin
        err         <= 1'b1;
        err_kind    <= hit_kind;
        err_channel <= hit_ch;
        err_reg     <= hit_reg;
        err_order   <= hit_ord;
      end
    end
  end

`ifdef RISCV_FORMAL
  // Formal property: no causality violation is ever reachable.
  always_comb assert (!err);
`endif

endmodule

// File: tb/tb_rvfi_causal_multi_check.sv
// Directed bench: three checker instances share one stimulus stream.
//   dut_a: NRET=2, CHECK_WAW=1, CNT_W=4
//   dut_b: NRET=2, CHECK_WAW=0, CNT_W=16
//   dut_c: NRET=1, CHECK_WAW=0 (channel 0 only)
module tb_rvfi_causal_multi_check;

  localparam int OW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [1:0]    valid = '0;
  logic [2*OW-1:0] order = '0;
  logic [9:0]    rs1 = '0, rs2 = '0, rd = '0;

  logic          a_err, b_err, c_err;
  logic [1:0]    a_kind, b_kind, c_kind;
  logic [1:0]    a_ch, b_ch;
  logic [0:0]    c_ch;
  logic [4:0]    a_reg, b_reg, c_reg;
  logic [OW-1:0] a_ord, b_ord, c_ord;
  logic [3:0]    a_cnt;
  logic [15:0]   b_cnt, c_cnt;

  int total = 0;
  int fails = 0;

  always #5 clock = ~clock;

  rvfi_causal_multi_check #(.NRET(2), .ORDER_W(OW), .CHECK_WAW(1), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(valid), .rvfi_order(order),
    .rvfi_rs1_addr(rs1), .rvfi_rs2_addr(rs2), .rvfi_rd_addr(rd),
    .err(a_err), .err_kind(a_kind), .err_channel(a_ch), .err_reg(a_reg),
    .err_order(a_ord), .checked_count(a_cnt)
  );

  rvfi_causal_multi_check #(.NRET(2), .ORDER_W(OW), .CHECK_WAW(0), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(valid), .rvfi_order(order),
    .rvfi_rs1_addr(rs1), .rvfi_rs2_addr(rs2), .rvfi_rd_addr(rd),
    .err(b_err), .err_kind(b_kind), .err_channel(b_ch), .err_reg(b_reg),
    .err_order(b_ord), .checked_count(b_cnt)
  );

  rvfi_causal_multi_check #(.NRET(1), .ORDER_W(OW), .CHECK_WAW(0), .CNT_W(16)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .rvfi_valid(valid[0]), .rvfi_order(order[OW-1:0]),
    .rvfi_rs1_addr(rs1[4:0]), .rvfi_rs2_addr(rs2[4:0]), .rvfi_rd_addr(rd[4:0]),
    .err(c_err), .err_kind(c_kind), .err_channel(c_ch), .err_reg(c_reg),
    .err_order(c_ord), .checked_count(c_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int c, input logic [OW-1:0] o,
                     input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
    valid[c]          = 1'b1;
    order[c*OW +: OW] = o;
    rs1[c*5 +: 5]     = a1;
    rs2[c*5 +: 5]     = a2;
    rd[c*5 +: 5]      = d;
  endtask

  task automatic clr();
    valid = '0; order = '0; rs1 = '0; rs2 = '0; rd = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_a_err", a_err, 0);
    chk("rst_a_kind", a_kind, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_c_err", c_err, 0);
    reset = 1'b1;

    // RAW across cycles, single channel
    put(0, 16'd10, 5'd5, 5'd0, 5'd0); tick();
    put(0, 16'd7, 5'd0, 5'd0, 5'd5); tick();
    chk("raw1_c_err", c_err, 1);
    chk("raw1_c_kind", c_kind, 1);
    chk("raw1_c_reg", c_reg, 5);
    chk("raw1_c_ord", c_ord, 7);
    chk("raw1_c_ch", c_ch, 0);
    chk("raw1_c_cnt", c_cnt, 1);
    chk("raw1_a_kind", a_kind, 1);
    rst_pulse();
    chk("async_rst_a_err", a_err, 0);
    chk("async_rst_a_cnt", a_cnt, 0);

    // Same-cycle RAW: lower channel reads with higher order
    put(0, 16'd9, 5'd3, 5'd0, 5'd0);
    put(1, 16'd8, 5'd0, 5'd0, 5'd3); tick();
    chk("sc_raw_a_err", a_err, 1);
    chk("sc_raw_a_kind", a_kind, 1);
    chk("sc_raw_a_ch", a_ch, 1);
    chk("sc_raw_a_reg", a_reg, 3);
    chk("sc_raw_a_ord", a_ord, 8);
    chk("sc_raw_b_ch", b_ch, 1);
    rst_pulse();
    // Swapped: reader on higher channel is not a violation
    put(0, 16'd8, 5'd0, 5'd0, 5'd3);
    put(1, 16'd9, 5'd3, 5'd0, 5'd0); tick();
    chk("sc_swap_a_err", a_err, 0);
    chk("sc_swap_b_err", b_err, 0);
    // Writers reading their own rd; ch1 newer than ch0
    put(0, 16'd50, 5'd7, 5'd0, 5'd7);
    put(1, 16'd51, 5'd7, 5'd0, 5'd7); tick();
    chk("self_rd_a_err", a_err, 0);
    chk("self_rd_a_cnt", a_cnt, 3);
    rst_pulse();

    // WAW across cycles
    put(0, 16'd20, 5'd0, 5'd0, 5'd8); tick();
    put(0, 16'd15, 5'd0, 5'd0, 5'd8); tick();
    chk("waw_a_err", a_err, 1);
    chk("waw_a_kind", a_kind, 2);
    chk("waw_a_reg", a_reg, 8);
    chk("waw_a_ord", a_ord, 15);
    chk("waw_b_err", b_err, 0);
    chk("waw_c_err", c_err, 0);
    rst_pulse();

    // x0-only traffic
    put(0, 16'd100, 5'd0, 5'd0, 5'd0); put(1, 16'd3, 5'd0, 5'd0, 5'd0); tick();
    put(0, 16'd1, 5'd0, 5'd0, 5'd0);   put(1, 16'd200, 5'd0, 5'd0, 5'd0); tick();
    put(0, 16'd0, 5'd0, 5'd0, 5'd0); tick();
    chk("x0_a_err", a_err, 0);
    chk("x0_a_cnt", a_cnt, 0);
    chk("x0_b_cnt", b_cnt, 0);

    // First-error hold
    put(0, 16'd30, 5'd4, 5'd0, 5'd0);
    put(1, 16'd31, 5'd0, 5'd6, 5'd0); tick();
    put(0, 16'd5, 5'd0, 5'd0, 5'd4); tick();
    put(0, 16'd6, 5'd0, 5'd0, 5'd6); tick();
    chk("hold_a_reg", a_reg, 4);
    chk("hold_a_ord", a_ord, 5);
    chk("hold_a_kind", a_kind, 1);
    chk("hold_b_reg", b_reg, 4);
    rst_pulse();
    chk("hold_rst_err", a_err, 0);
    chk("hold_rst_reg", a_reg, 0);
    chk("hold_rst_ord", a_ord, 0);
    chk("hold_rst_kind", a_kind, 0);
    put(0, 16'd5, 5'd0, 5'd0, 5'd4); tick();
    chk("hist_gone_a_err", a_err, 0);
    chk("hist_gone_b_err", b_err, 0);
    rst_pulse();

    // Counter saturation: 20 clean writers
    for (int i = 0; i < 10; i++) begin
      put(0, 16'(100 + 2*i), 5'd0, 5'd0, 5'd10);
      put(1, 16'(101 + 2*i), 5'd0, 5'd0, 5'd11);
      tick();
    end
    chk("sat_a_cnt", a_cnt, 15);
    chk("sat_b_cnt", b_cnt, 20);
    chk("sat_a_err", a_err, 0);

    // Enable low: detection and counting suppressed, history still recorded
    enable = 1'b0;
    put(0, 16'd500, 5'd12, 5'd0, 5'd0); tick();
    put(0, 16'd400, 5'd0, 5'd0, 5'd12); tick();
    chk("en0_a_err", a_err, 0);
    chk("en0_b_cnt", b_cnt, 20);
    enable = 1'b1;
    put(0, 16'd401, 5'd0, 5'd0, 5'd12); tick();
    chk("en1_a_err", a_err, 1);
    chk("en1_a_kind", a_kind, 1);
    chk("en1_a_reg", a_reg, 12);
    chk("en1_a_ord", a_ord, 401);
    chk("en1_a_cnt", a_cnt, 15);
    chk("en1_b_cnt", b_cnt, 21);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
